// File: rtl/cb_pkg.sv
// cb_pkg: shared types and sizing helpers for the parametrised connection/switch blocks
//   cb_state_t  : configuration state machine encoding
//   cb_clog2    : ceiling log2
//   cb_sel_w    : select width of a 2*FC-input mux (at least 1)
//   cb_cfg_bits : configuration chain length for n_ipin muxes
package cb_pkg;
   typedef enum logic [1:0] {UNCFG, LOADING, ACTIVE} cb_state_t;

   function automatic int cb_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int cb_sel_w(input int fc);
      return (cb_clog2(2 * fc) < 1) ? 1 : cb_clog2(2 * fc);
   endfunction

   function automatic int cb_cfg_bits(input int n_ipin, input int fc);
      return n_ipin * cb_sel_w(fc);
   endfunction
endpackage

// File: rtl/cb_ipin_mux.sv
// cb_ipin_mux: 2*FC-input track selector for one grid input pin
//   sel   : mux select from the active configuration
//   en    : gates the pin to 0 while no configuration is applied
//   left  : left-side channel tracks
//   right : right-side channel tracks
//   pin   : grid pin drive
module cb_ipin_mux
   import cb_pkg::*;
#(
   parameter int CHAN_WIDTH = 4,
   parameter int FC         = 2,
   parameter int STRIDE     = 1,
   parameter int IDX        = 0,
   parameter int SEL_W      = cb_sel_w(FC)
) (
   input  logic [SEL_W-1:0]      sel,
   input  logic                  en,
   input  logic [CHAN_WIDTH-1:0] left,
   input  logic [CHAN_WIDTH-1:0] right,
   output logic                  pin
);
   // padded to a full power of two so unused selects read a hard 0
   logic [(1<<SEL_W)-1:0] cand;
   logic                  unused_tracks;

   for (genvar k = 0; k < (1 << SEL_W); k++) begin : g_cand
      if (k < FC) begin : g_l
         assign cand[k] = left[(IDX * STRIDE + k) % CHAN_WIDTH];
      end else if (k < 2 * FC) begin : g_r
         assign cand[k] = right[(IDX * STRIDE + k - FC) % CHAN_WIDTH];
      end else begin : g_z
         assign cand[k] = 1'b0;
      end
   end

   // only a window of each channel is visible to this pin
   assign unused_tracks = ^{left, right};
   assign pin = en & cand[sel];
endmodule

// File: rtl/cbx_param.sv
// cbx_param: parametrised X-channel connection block with double-buffered configuration
//   prog_clk, prog_reset_n         : config clock, async active-low reset
//   cfg_en, ccff_head, cfg_commit  : serial shift enable/data, commit pulse
//   chanx_left_in/right_in         : channel tracks in
//   chanx_left_out/right_out       : straight-through tracks out
//   ipin_out                       : grid input pin drives
//   ccff_tail                      : serial config out
//   cfg_valid, cfg_busy, cfg_err   : configuration status
module cbx_param
   import cb_pkg::*;
#(
   parameter int CHAN_WIDTH = 4,
   parameter int NUM_IPIN   = 3,
   parameter int FC         = 2,
   parameter int STRIDE     = 1,
   parameter int STRICT_LEN = 0
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset_n,
   input  logic                  cfg_en,
   input  logic                  ccff_head,
   input  logic                  cfg_commit,
   input  logic [CHAN_WIDTH-1:0] chanx_left_in,
   input  logic [CHAN_WIDTH-1:0] chanx_right_in,
   output logic [CHAN_WIDTH-1:0] chanx_left_out,
   output logic [CHAN_WIDTH-1:0] chanx_right_out,
   output logic [NUM_IPIN-1:0]   ipin_out,
   output logic                  ccff_tail,
   output logic                  cfg_valid,
   output logic                  cfg_busy,
   output logic                  cfg_err
);
   localparam int SEL_W    = cb_sel_w(FC);
   localparam int CFG_BITS = cb_cfg_bits(NUM_IPIN, FC);
   localparam int CNT_W    = cb_clog2(CFG_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS + 1);

   cb_state_t           state, state_nxt;
   logic [CFG_BITS-1:0] shift, active;
   logic [CNT_W-1:0]    shift_cnt;
   logic                commit_ok, commit_bad;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;
   assign ccff_tail       = shift[CFG_BITS-1];
   assign cfg_busy        = (state == LOADING);

   // a commit coinciding with a shift is always refused
   assign commit_ok  = cfg_commit & ~cfg_en & ((STRICT_LEN == 0) || (shift_cnt == CNT_FULL));
   assign commit_bad = cfg_commit & ~commit_ok;

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state     <= UNCFG;
         shift     <= '0;
         active    <= '0;
         shift_cnt <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cfg_en) shift <= CFG_BITS'({shift, ccff_head});
         if (commit_ok) begin
            active    <= shift;
            cfg_valid <= 1'b1;
            cfg_err   <= 1'b0;
            shift_cnt <= '0;
         end else begin
            if (commit_bad) cfg_err <= 1'b1;
            if (cfg_en && shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         UNCFG:   state_nxt = commit_ok ? ACTIVE : cfg_en ? LOADING : UNCFG;
         LOADING: state_nxt = commit_ok ? ACTIVE : !commit_bad ? LOADING : cfg_valid ? ACTIVE : UNCFG;
         ACTIVE:  state_nxt = cfg_en ? LOADING : ACTIVE;
         default: state_nxt = UNCFG;
      endcase
   end

   for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
      cb_ipin_mux #(
         .CHAN_WIDTH(CHAN_WIDTH),
         .FC        (FC),
         .STRIDE    (STRIDE),
         .IDX       (i),
         .SEL_W     (SEL_W)
      ) u_mux (
         .sel  (active[i*SEL_W +: SEL_W]),
         .en   (cfg_valid),
         .left (chanx_left_in),
         .right(chanx_right_in),
         .pin  (ipin_out[i])
      );
   end
endmodule
